fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO among NREQ producers in the clk1 domain. It picks one requester per cycle, drives the FIFO write_en/din pair, and returns a same-cycle grant. It honours the FIFO's full flag and the FIFO rule that write and read must never be enabled together.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 56 +++++
 rtl/fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM state (IDLE = 0, BURST = 1)
//   - ptr_width() : width of the rotation pointer / owner index, clog2(NREQ)
//   - NREQ_DEF, WIDTH_DEF, BURST_LEN_DEF : defaults shared with the FIFO
package fifo_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit index field.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating priority encoder. Searches req starting at index
// ptr, then ptr+1, ... wrapping modulo NREQ, and selects the first set bit.
// Ports:
//   req    in  NREQ  candidate requests
//   ptr    in  PW    highest-priority index (must be < NREQ)
//   gnt    out NREQ  one-hot grant, all zero when req is zero
//   winner out PW    index of the granted bit, 0 when req is zero
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   winner
);

    // One spare bit so ptr + offset cannot overflow before the modulo fold.
    localparam int SW = PW + 1;

    genvar gi;

    logic [NREQ-1:0] w_found;
    logic [NREQ-1:0] w_gnt_acc [NREQ+1];
    logic [PW-1:0]   w_win_acc [NREQ+1];

    assign w_found[0]   = 1'b0;
    assign w_gnt_acc[0] = '0;
    assign w_win_acc[0] = '0;

    // Stage gi looks at requester (ptr + gi) mod NREQ; it wins only if no
    // earlier stage (closer to ptr) already found a request.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stage
            logic [SW-1:0] w_sum;
            logic [PW-1:0] w_idx;
            logic          w_take;

            assign w_sum  = {1'b0, ptr} + SW'(gi);
            assign w_idx  = (w_sum >= SW'(NREQ)) ? PW'(w_sum - SW'(NREQ)) : PW'(w_sum);
            assign w_take = req[w_idx] & ~w_found[gi];

            if (gi < NREQ - 1) begin : g_chain
                assign w_found[gi+1] = w_found[gi] | req[w_idx];
            end

            assign w_gnt_acc[gi+1] = w_gnt_acc[gi] | (w_take ? (NREQ'(1) << w_idx) : '0);
            assign w_win_acc[gi+1] = w_win_acc[gi] | (w_take ? w_idx : '0);
        end
    endgenerate

    assign gnt    = w_gnt_acc[NREQ];
    assign winner = w_win_acc[NREQ];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of the asynchronous FIFO
// among NREQ producers in the clk1 domain. Grants are combinational and
// one-hot; a word transfers at the clk1 edge where req[i] & gnt[i].
// No grant is issued while the FIFO is full, while the consumer read enable
// is high (write and read must never be enabled together), or during reset.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   defined   : a winner keeps the port for up to BURST_LEN consecutive beats
//   undefined : grants rotate strictly per beat; owner_vld is tied to 0
//
// Ports:
//   clk1          in  1           write-domain clock
//   rst           in  1           asynchronous active-high reset
//   req           in  NREQ        per-requester write request
//   req_data      in  NREQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//   gnt           out NREQ        one-hot combinational grant
//   fifo_full     in  1           FIFO full flag
//   fifo_read_en  in  1           consumer read enable seen by the FIFO
//   fifo_write_en out 1           FIFO write enable (= |gnt)
//   fifo_din      out WIDTH       granted requester's data, 0 when idle
//   owner         out PW          index of the last granted requester
//   owner_vld     out 1           high while a burst is in progress
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NREQ      = NREQ_DEF,
    parameter int  WIDTH     = WIDTH_DEF,
    parameter int  BURST_LEN = BURST_LEN_DEF,
    localparam int PW        = ptr_width(NREQ)
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  fifo_full,
    input  logic                  fifo_read_en,
    output logic                  fifo_write_en,
    output logic [WIDTH-1:0]      fifo_din,
    output logic [PW-1:0]         owner,
    output logic                  owner_vld
);

    // An out-of-range configuration never grants instead of mis-arbitrating.
    localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) &&
                            (BURST_LEN >= 1) && (BURST_LEN <= 15);

    genvar gi;

    logic              w_stall;
    logic              w_hold;
    logic [NREQ-1:0]   w_req_cfg;
    logic [NREQ-1:0]   w_req_elig;
    logic [NREQ-1:0]   w_pick_gnt;
    logic [PW-1:0]     w_winner;
    logic [PW-1:0]     w_winner_inc;
    logic [WIDTH-1:0]  w_din_acc [NREQ+1];

    logic [PW-1:0]     r_ptr_reg;
    logic [PW-1:0]     r_ptr_next;
    logic [PW-1:0]     r_owner_reg;
    logic [PW-1:0]     r_owner_next;

    // Reset forces the grant low combinationally; the registers only need
    // the full/read part because reset already dominates in the flops.
    assign w_stall   = fifo_full | fifo_read_en | rst;
    assign w_hold    = fifo_full | fifo_read_en;
    assign w_req_cfg = CFG_OK ? req : '0;

    // Pointer increments wrap at NREQ, which need not be a power of two.
    assign w_winner_inc = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

`ifdef FIFO_ARB_BURST_EN
    arb_state_t      r_state_reg;
    arb_state_t      r_state_next;
    logic [3:0]      r_beats_reg;
    logic [3:0]      r_beats_next;
    logic            r_owner_vld_reg;
    logic            r_owner_vld_next;
    logic [NREQ-1:0] w_owner_mask;
    logic [PW-1:0]   w_owner_inc;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_owner_mask
            assign w_owner_mask[gi] = (r_owner_reg == PW'(gi));
        end
    endgenerate

    // During a burst only the owner may be picked; rr_pick then returns the
    // owner if its request is up, regardless of ptr.
    assign w_req_elig  = (r_state_reg == BURST) ? (w_req_cfg & w_owner_mask) : w_req_cfg;
    assign w_owner_inc = (r_owner_reg == PW'(NREQ - 1)) ? '0 : r_owner_reg + 1'b1;
`else
    assign w_req_elig  = w_req_cfg;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (w_req_elig),
        .ptr    (r_ptr_reg),
        .gnt    (w_pick_gnt),
        .winner (w_winner)
    );

    assign gnt           = w_stall ? '0 : w_pick_gnt;
    assign fifo_write_en = |gnt;

    // AND-OR data mux; gnt is one-hot so at most one slice is non-zero.
    assign w_din_acc[0] = '0;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_din
            assign w_din_acc[gi+1] = w_din_acc[gi] |
                                     (gnt[gi] ? req_data[gi*WIDTH +: WIDTH] : '0);
        end
    endgenerate
    assign fifo_din = w_din_acc[NREQ];

    assign owner = r_owner_reg;

`ifdef FIFO_ARB_BURST_EN
    assign owner_vld = r_owner_vld_reg;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_ptr_reg       <= '0;
            r_owner_reg     <= '0;
            r_state_reg     <= IDLE;
            r_beats_reg     <= '0;
            r_owner_vld_reg <= 1'b0;
        end else begin
            r_ptr_reg       <= r_ptr_next;
            r_owner_reg     <= r_owner_next;
            r_state_reg     <= r_state_next;
            r_beats_reg     <= r_beats_next;
            r_owner_vld_reg <= r_owner_vld_next;
        end
    end

    always_comb begin
        r_ptr_next       = r_ptr_reg;
        r_owner_next     = r_owner_reg;
        r_state_next     = r_state_reg;
        r_beats_next     = r_beats_reg;
        r_owner_vld_next = r_owner_vld_reg;

        case (r_state_reg)
            IDLE: begin
                if (fifo_write_en) begin
                    r_owner_next = w_winner;
                    if (BURST_LEN == 1) begin
                        r_ptr_next = w_winner_inc;
                    end else begin
                        r_state_next     = BURST;
                        r_beats_next     = 4'd1;
                        r_owner_vld_next = 1'b1;
                    end
                end
            end
            BURST: begin
                // Under full/read everything holds, including a burst whose
                // owner has just dropped its request.
                if (!w_hold) begin
                    if (fifo_write_en) begin
                        r_beats_next = r_beats_reg + 4'd1;
                        if (r_beats_reg + 4'd1 == 4'(BURST_LEN)) begin
                            r_ptr_next       = w_owner_inc;
                            r_state_next     = IDLE;
                            r_beats_next     = '0;
                            r_owner_vld_next = 1'b0;
                        end
                    end else begin
                        r_ptr_next       = w_owner_inc;
                        r_state_next     = IDLE;
                        r_beats_next     = '0;
                        r_owner_vld_next = 1'b0;
                    end
                end
            end
            default: begin
                r_state_next = IDLE;
            end
        endcase
    end
`else
    assign owner_vld = 1'b0;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_ptr_reg   <= '0;
            r_owner_reg <= '0;
        end else begin
            r_ptr_reg   <= r_ptr_next;
            r_owner_reg <= r_owner_next;
        end
    end

    // A grant already implies no stall, so the write enable alone gates
    // the pointer and owner update.
    always_comb begin
        r_ptr_next   = r_ptr_reg;
        r_owner_next = r_owner_reg;
        if (fifo_write_en) begin
            r_ptr_next   = w_winner_inc;
            r_owner_next = w_winner;
        end
    end
`endif

endmodule
